multi_way_signal_controller: RTL

//   Parametrised N-approach traffic signal controller; successor to the fixed two-road sequencer.

---
 rtl/tlc_pkg.sv | 26 ++
 rtl/rr_next_dir.sv | 29 ++
 rtl/multi_way_signal_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the multi-way signal controller: phase encoding
// and the per-approach lamp decode.
package tlc_pkg;

    localparam logic [1:0] PH_GREEN   = 2'd0;
    localparam logic [1:0] PH_YELLOW  = 2'd1;
    localparam logic [1:0] PH_ALL_RED = 2'd2;
    localparam logic [1:0] PH_FLASH   = 2'd3;

    // Lamp state of one approach, returned as {green, yellow, red}.
    // Outside FLASH exactly one lamp is lit; non-owners are always red.
    function automatic logic [2:0] lamp_decode(input logic [1:0] phase,
                                               input logic       is_active,
                                               input logic       flash_on);
        logic [2:0] lamp;
        case (phase)
            PH_GREEN:   lamp = is_active ? 3'b100 : 3'b001;
            PH_YELLOW:  lamp = is_active ? 3'b010 : 3'b001;
            PH_ALL_RED: lamp = 3'b001;
            PH_FLASH:   lamp = {2'b00, flash_on};
            default:    lamp = 3'b001;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin selector: finds the first requesting approach after the
// current owner, wrapping around and ending with the owner itself.
module rr_next_dir #(
    parameter int NUM_DIR = 2,
    parameter int DW      = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] req,
    input  logic [DW-1:0]      active_dir,
    output logic [DW-1:0]      next_dir,
    output logic               found
);

    logic [2*NUM_DIR-1:0] dbl_s;
    logic [2*NUM_DIR-1:0] rot_s;

    // Rotate the request vector so bit j is approach active_dir+1+j, then pick the lowest set bit.
    always_comb begin
        dbl_s    = {req, req};
        rot_s    = dbl_s >> (32'(active_dir) + 32'd1);
        next_dir = active_dir;
        found    = 1'b0;
        // Descending scan: the smallest offset is assigned last and therefore wins.
        for (int j = NUM_DIR - 1; j >= 0; j--) begin
            found    = rot_s[j] ? 1'b1 : found;
            next_dir = rot_s[j] ? DW'((32'(active_dir) + 32'(j) + 32'd1) % NUM_DIR) : next_dir;
        end
    end

endmodule

// File: rtl/multi_way_signal_controller.sv
// N-approach traffic signal controller. Requests are latched per approach
// and served round-robin; green is held between MIN_GREEN and MAX_GREEN
// ticks, followed by yellow and all-red clearance. flash forces an all-red
// flashing fault/night mode. Phase durations are assumed not to exceed
// MAX_GREEN, since the shared timer saturates at MAX_GREEN-1.
module multi_way_signal_controller
    import tlc_pkg::*;
#(
    parameter  int NUM_DIR       = 2,
    parameter  int MIN_GREEN     = 6,
    parameter  int MAX_GREEN     = 20,
    parameter  int YELLOW_TICKS  = 1,
    parameter  int ALL_RED_TICKS = 1,
    localparam int DW            = $clog2(NUM_DIR),
    localparam int TW            = $clog2(MAX_GREEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               flash,
    input  logic [NUM_DIR-1:0] sensor,
    output logic [NUM_DIR-1:0] green,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] red,
    output logic [DW-1:0]      active_dir,
    output logic [1:0]         phase
);

    localparam logic [TW-1:0]      TMR_ZERO = TW'(0);
    localparam logic [TW-1:0]      TMR_ONE  = TW'(1);
    localparam logic [TW-1:0]      MIN_END  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0]      MAX_END  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0]      Y_END    = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0]      AR_END   = TW'(ALL_RED_TICKS - 1);
    localparam logic [NUM_DIR-1:0] DIR_ONE  = {{(NUM_DIR-1){1'b0}}, 1'b1};
    localparam logic [NUM_DIR-1:0] DIR_NONE = {NUM_DIR{1'b0}};

    logic [1:0]         phase_r;
    logic [DW-1:0]      active_dir_r;
    logic [TW-1:0]      tmr_r;
    logic [NUM_DIR-1:0] req_r;
    logic               flash_on_r;

    logic [1:0]         phase_nx_s;
    logic [DW-1:0]      dir_nx_s;
    logic [TW-1:0]      tmr_nx_s;
    logic [NUM_DIR-1:0] req_nx_s;
    logic               flash_on_nx_s;

    logic [NUM_DIR-1:0] active_mask_s;
    logic [NUM_DIR-1:0] set_s;
    logic [NUM_DIR-1:0] clr_s;
    logic [TW-1:0]      tmr_inc_s;
    logic               other_req_s;
    logic               green_done_s;
    logic [DW-1:0]      next_dir_s;
    logic               found_s;
    logic [2:0]         lamp_s [NUM_DIR];

    rr_next_dir #(
        .NUM_DIR (NUM_DIR),
        .DW      (DW)
    ) u_rr (
        .req        (req_r),
        .active_dir (active_dir_r),
        .next_dir   (next_dir_s),
        .found      (found_s)
    );

    // Next-state logic: flash override first, then tick-driven phase sequencing and request latching.
    always_comb begin
        active_mask_s = DIR_ONE << active_dir_r;
        other_req_s   = |(req_r & ~active_mask_s);
        tmr_inc_s     = (tmr_r == MAX_END) ? tmr_r : (tmr_r + TMR_ONE);
        // Green may end early only once the minimum has elapsed and the owner's lane is empty.
        green_done_s  = ((tmr_r >= MIN_END) && !(|(sensor & active_mask_s))) || (tmr_r == MAX_END);
        // The owner's own sensor is ignored while it is green; everyone else always latches.
        set_s         = sensor & ~((phase_r == PH_GREEN) ? active_mask_s : DIR_NONE);
        phase_nx_s    = phase_r;
        dir_nx_s      = active_dir_r;
        tmr_nx_s      = tmr_r;
        flash_on_nx_s = flash_on_r;
        clr_s         = DIR_NONE;

        if (flash) begin
            if (phase_r != PH_FLASH) begin
                phase_nx_s    = PH_FLASH;
                tmr_nx_s      = TMR_ZERO;
                flash_on_nx_s = 1'b1;
            end else begin
                flash_on_nx_s = tick ? ~flash_on_r : flash_on_r;
            end
        end else if (phase_r == PH_FLASH) begin
            // Leaving flash always passes through a full all-red clearance.
            phase_nx_s = PH_ALL_RED;
            tmr_nx_s   = TMR_ZERO;
        end else if (tick) begin
            tmr_nx_s = tmr_inc_s;
            case (phase_r)
                PH_GREEN: begin
                    if (other_req_s && green_done_s) begin
                        phase_nx_s = PH_YELLOW;
                        tmr_nx_s   = TMR_ZERO;
                    end else begin
                        phase_nx_s = PH_GREEN;
                    end
                end
                PH_YELLOW: begin
                    if (tmr_r == Y_END) begin
                        phase_nx_s = PH_ALL_RED;
                        tmr_nx_s   = TMR_ZERO;
                    end else begin
                        phase_nx_s = PH_YELLOW;
                    end
                end
                PH_ALL_RED: begin
                    if (tmr_r == AR_END) begin
                        phase_nx_s = PH_GREEN;
                        tmr_nx_s   = TMR_ZERO;
                        dir_nx_s   = found_s ? next_dir_s : active_dir_r;
                        clr_s      = DIR_ONE << dir_nx_s;
                    end else begin
                        phase_nx_s = PH_ALL_RED;
                    end
                end
                default: begin
                    phase_nx_s = PH_ALL_RED;
                    tmr_nx_s   = TMR_ZERO;
                end
            endcase
        end else begin
            tmr_nx_s = tmr_r;
        end

        // Clearing the bit of the approach entering green takes priority over a same-cycle set.
        req_nx_s = (req_r | set_s) & ~clr_s;
    end

    // State registers with synchronous reset; pending requests are discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r      <= PH_GREEN;
            active_dir_r <= {DW{1'b0}};
            tmr_r        <= TMR_ZERO;
            req_r        <= DIR_NONE;
            flash_on_r   <= 1'b0;
        end else begin
            phase_r      <= phase_nx_s;
            active_dir_r <= dir_nx_s;
            tmr_r        <= tmr_nx_s;
            req_r        <= req_nx_s;
            flash_on_r   <= flash_on_nx_s;
        end
    end

    // Lamp decode per approach straight from the state registers.
    always_comb begin
        green  = DIR_NONE;
        yellow = DIR_NONE;
        red    = DIR_NONE;
        for (int i = 0; i < NUM_DIR; i++) begin
            lamp_s[i] = lamp_decode(phase_r, active_mask_s[i], flash_on_r);
            green[i]  = lamp_s[i][2];
            yellow[i] = lamp_s[i][1];
            red[i]    = lamp_s[i][0];
        end
    end

    assign phase      = phase_r;
    assign active_dir = active_dir_r;

endmodule
